// File: rtl/shift_reg_seq.sv
// ---------------------------------------------------------------------------
// shift_reg_seq : parallel-load shift register with a multi-step shift sequencer
// Optional CARRY output (bit shifted out) when SHREG_CARRY_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_reg_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LD,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  START,
  input  logic                  DIR,
  input  logic [1:0]            MODE,
  input  logic [CNT_W-1:0]      COUNT,
  input  logic                  LeftIn,
  input  logic                  RightIn,
`ifdef SHREG_CARRY_EN
  output logic                  CARRY,
`endif
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  BUSY,
  output logic                  DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;

  state_t                  state;
  logic [CNT_W-1:0]        remaining;
  logic                    dir_lat;
  logic [1:0]              mode_lat;
  logic [DATA_WIDTH-1:0]   shifted;

  // One-bit shift of the current contents using the latched command;
  // serial fill bits are taken live from the inputs.
  always_comb begin
    shifted = Q;
    if (!dir_lat) begin
      case (mode_lat)
        MODE_ROT: shifted = {Q[DATA_WIDTH-2:0], Q[DATA_WIDTH-1]};
        2'b11:    shifted = {Q[DATA_WIDTH-2:0], RightIn};
        default:  shifted = {Q[DATA_WIDTH-2:0], 1'b0};
      endcase
    end else begin
      case (mode_lat)
        MODE_LOG: shifted = {1'b0, Q[DATA_WIDTH-1:1]};
        MODE_ARI: shifted = {Q[DATA_WIDTH-1], Q[DATA_WIDTH-1:1]};
        MODE_ROT: shifted = {Q[0], Q[DATA_WIDTH-1:1]};
        default:  shifted = {LeftIn, Q[DATA_WIDTH-1:1]};
      endcase
    end
  end

`ifdef SHREG_CARRY_EN
  logic shift_out;
  always_comb begin
    shift_out = dir_lat ? Q[0] : Q[DATA_WIDTH-1];
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      Q         <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      remaining <= '0;
      dir_lat   <= 1'b0;
      mode_lat  <= 2'b00;
`ifdef SHREG_CARRY_EN
      CARRY     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          BUSY <= 1'b0;
          DONE <= 1'b0;
          if (LD) begin
            Q <= D;
`ifdef SHREG_CARRY_EN
            CARRY <= 1'b0;
`endif
          end else if (START) begin
            dir_lat  <= DIR;
            mode_lat <= MODE;
            if (COUNT == '0) begin
              state <= FIN;
              DONE  <= 1'b1;
            end else begin
              state     <= SHIFT;
              BUSY      <= 1'b1;
              remaining <= COUNT;
            end
          end
        end

        SHIFT: begin
          Q         <= shifted;
          remaining <= remaining - CNT_W'(1);
`ifdef SHREG_CARRY_EN
          CARRY     <= shift_out;
`endif
          if (remaining == CNT_W'(1)) begin
            state <= FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end

        FIN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_seq : self-checking bench for shift_reg_seq (DATA_WIDTH=8, CNT_W=4)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shift_reg_seq;

  localparam int W = 8;
  localparam int M = 256;

  logic       CLK = 1'b0;
  logic       RST, LD, START, DIR, LeftIn, RightIn;
  logic [7:0] D;
  logic [1:0] MODE;
  logic [3:0] COUNT;
  logic [7:0] Q;
  logic       BUSY, DONE;
`ifdef SHREG_CARRY_EN
  logic       CARRY;
`endif

  int compared   = 0;
  int mismatched = 0;
  int mq         = 0;
  int mcarry     = 0;

  shift_reg_seq #(.DATA_WIDTH(W), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .LD(LD), .D(D), .START(START), .DIR(DIR),
    .MODE(MODE), .COUNT(COUNT), .LeftIn(LeftIn), .RightIn(RightIn),
`ifdef SHREG_CARRY_EN
    .CARRY(CARRY),
`endif
    .Q(Q), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Reference: value after one shift, from the arithmetic meaning of each mode.
  function automatic int ref_step(input int q, input bit dir, input int mode,
                                  input int li, input int ri);
    int r;
    if (!dir) begin
      r = (q * 2) % M;
      if (mode == 2) r = r + q / (M / 2);
      else if (mode == 3) r = r + ri;
    end else begin
      r = q / 2;
      if (mode == 1) r = r + (q / (M / 2)) * (M / 2);
      else if (mode == 2) r = r + (q % 2) * (M / 2);
      else if (mode == 3) r = r + li * (M / 2);
    end
    return r;
  endfunction

  function automatic int ref_out(input int q, input bit dir);
    return dir ? (q % 2) : (q / (M / 2));
  endfunction

  // Called right after a falling edge; returns right after a falling edge.
  task automatic do_load(input logic [7:0] v);
    LD = 1'b1; D = v; START = 1'b0;
    @(negedge CLK);
    LD = 1'b0;
    mq = v; mcarry = 0;
    compared++;
    if (Q !== v) begin
      mismatched++;
      $display("FAIL load: Q=%h expected %h", Q, v);
    end
  endtask

  task automatic run_cmd(input bit dir, input logic [1:0] mode, input logic [3:0] cnt,
                         input bit use_fills, input logic [15:0] fills,
                         input int expect_q, input string name);
    int n;
    int li, ri;
    n = cnt;
    DIR = dir; MODE = mode; COUNT = cnt; START = 1'b1; LD = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    for (int k = 1; k <= n; k++) begin
      compared++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin
        mismatched++;
        $display("FAIL %s busy step %0d: BUSY=%b DONE=%b expected 1 0", name, k, BUSY, DONE);
      end
      li = int'($urandom_range(1, 0));
      ri = int'($urandom_range(1, 0));
      if (use_fills) begin
        li = int'(fills[k-1]);
        ri = int'(fills[k-1]);
      end
      LeftIn = li[0]; RightIn = ri[0];
      // Activity the sequencer must ignore while shifting.
      DIR   = 1'($urandom_range(1, 0));
      MODE  = 2'($urandom_range(3, 0));
      COUNT = 4'($urandom_range(15, 0));
      LD    = 1'($urandom_range(1, 0));
      START = 1'($urandom_range(1, 0));
      D     = 8'($urandom_range(255, 0));
      mcarry = ref_out(mq, dir);
      mq = ref_step(mq, dir, int'(mode), li, ri);
      @(negedge CLK);
      compared++;
      if (Q !== mq[7:0]) begin
        mismatched++;
        $display("FAIL %s Q step %0d: Q=%h expected %h", name, k, Q, mq[7:0]);
      end
    end
    LD = 1'b0; START = 1'b0;
    compared++;
    if (DONE !== 1'b1 || BUSY !== 1'b0) begin
      mismatched++;
      $display("FAIL %s done: DONE=%b BUSY=%b expected 1 0", name, DONE, BUSY);
    end
    if (expect_q >= 0) begin
      compared++;
      if (Q !== expect_q[7:0]) begin
        mismatched++;
        $display("FAIL %s result: Q=%h expected %h", name, Q, expect_q[7:0]);
      end
    end
`ifdef SHREG_CARRY_EN
    compared++;
    if (CARRY !== mcarry[0]) begin
      mismatched++;
      $display("FAIL %s carry: CARRY=%b expected %b", name, CARRY, mcarry[0]);
    end
`endif
    // LD/START during the done cycle must be ignored.
    LD = 1'b1; D = ~mq[7:0]; START = 1'b1; COUNT = 4'd5;
    @(negedge CLK);
    LD = 1'b0; START = 1'b0;
    compared++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || Q !== mq[7:0]) begin
      mismatched++;
      $display("FAIL %s idle: DONE=%b BUSY=%b Q=%h expected 0 0 %h", name, DONE, BUSY, Q, mq[7:0]);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; LD = 1'b0; START = 1'b0; DIR = 1'b0; MODE = 2'b00;
    COUNT = 4'd0; LeftIn = 1'b0; RightIn = 1'b0; D = 8'h00;
    repeat (3) @(negedge CLK);
    compared++;
    if (Q !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      mismatched++;
      $display("FAIL reset: Q=%h BUSY=%b DONE=%b expected 00 0 0", Q, BUSY, DONE);
    end
    RST = 1'b0;
    @(negedge CLK);
    mq = 0; mcarry = 0;
  endtask

  task automatic test_logical_right();
    do_load(8'hB4);
    run_cmd(1'b1, 2'b00, 4'd3, 1'b0, 16'h0, 'h16, "logical_right");
  endtask

  task automatic test_arith_right();
    do_load(8'hB4);
    run_cmd(1'b1, 2'b01, 4'd2, 1'b0, 16'h0, 'hED, "arith_right_neg");
    do_load(8'h34);
    run_cmd(1'b1, 2'b01, 4'd2, 1'b0, 16'h0, 'h0D, "arith_right_pos");
  endtask

  task automatic test_rotate();
    do_load(8'h81);
    run_cmd(1'b0, 2'b10, 4'd1, 1'b0, 16'h0, 'h03, "rotate_left1");
    run_cmd(1'b0, 2'b10, 4'd8, 1'b0, 16'h0, 'h03, "rotate_left8");
    run_cmd(1'b0, 2'b00, 4'd8, 1'b0, 16'h0, 'h00, "logical_left8");
  endtask

  task automatic test_serial_and_zero();
    do_load(8'h00);
    // RightIn 1,0,1,1 on successive shift edges
    run_cmd(1'b0, 2'b11, 4'd4, 1'b1, 16'b1101, 'h0B, "serial_left");
    run_cmd(1'b0, 2'b11, 4'd0, 1'b0, 16'h0, 'h0B, "zero_count");
  endtask

  task automatic test_reset_mid_command();
    do_load(8'h5A);
    DIR = 1'b0; MODE = 2'b00; COUNT = 4'd6; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    compared++;
    if (Q !== 8'hB4 || BUSY !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset first shift: Q=%h BUSY=%b expected b4 1", Q, BUSY);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    compared++;
    if (Q !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset: Q=%h BUSY=%b DONE=%b expected 00 0 0", Q, BUSY, DONE);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      compared++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || Q !== 8'h00) begin
        mismatched++;
        $display("FAIL midreset after %0d: DONE=%b BUSY=%b Q=%h expected 0 0 00", i, DONE, BUSY, Q);
      end
    end
    mq = 0; mcarry = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3, 0) == 0) do_load(8'($urandom_range(255, 0)));
      run_cmd(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
              4'($urandom_range(15, 0)), 1'b0, 16'h0, -1, "random");
    end
  endtask

`ifdef SHREG_CARRY_EN
  task automatic test_carry();
    do_load(8'h80);
    run_cmd(1'b0, 2'b00, 4'd1, 1'b0, 16'h0, 'h00, "carry_left");
    compared++;
    if (CARRY !== 1'b1) begin
      mismatched++;
      $display("FAIL carry_set: CARRY=%b expected 1", CARRY);
    end
    do_load(8'h01);
    compared++;
    if (CARRY !== 1'b0) begin
      mismatched++;
      $display("FAIL carry_clear: CARRY=%b expected 0", CARRY);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_logical_right();
    test_arith_right();
    test_rotate();
    test_serial_and_zero();
    test_random();
`ifdef SHREG_CARRY_EN
    test_carry();
`endif
    test_reset_mid_command();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_reg_seq.md
Name: shift_reg_seq

Overview:
- Parametrised, multi-mode sequential shift register for the divider and other calculator datapaths.
- Supports parallel load and single-step shifts, like the existing 4-bit shift register.
- Adds a command-driven multi-step sequencer: logical, arithmetic, rotate or serial-fill shifts by a programmable count, one bit per cycle.
- Signals progress with busy/done so a control FSM can issue a command and wait for completion.

Parameters:
- DATA_WIDTH, 8, register width in bits (min 2).
- CNT_W, 4, width of shift-count input; max count is 2^CNT_W-1.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- LD  in  1  parallel load of D (idle only).
- D  in  DATA_WIDTH  parallel load data.
- START  in  1  begin a multi-step shift command (idle only).
- DIR  in  1  0 = shift left (toward MSB), 1 = shift right.
- MODE  in  2  00 logical, 01 arithmetic, 10 rotate, 11 serial-fill.
- COUNT  in  CNT_W  number of single-bit shifts to perform.
- LeftIn  in  1  serial fill bit entering the MSB on right shifts (MODE 11).
- RightIn  in  1  serial fill bit entering the LSB on left shifts (MODE 11).
- Q  out  DATA_WIDTH  register contents.
- BUSY  out  1  high while shifting.
- DONE  out  1  one-cycle pulse after a command completes.

Behaviour:
- Reset: RST is synchronous, active-high, clock CLK. RST has highest priority and is effective mid-command. On reset: Q=0, BUSY=0, DONE=0, state=IDLE, count and latched-command registers cleared.
- States: IDLE, SHIFT, FIN.
- IDLE priority:
  - LD=1: Q<=D. LD wins over START; START is ignored that cycle.
  - else START=1: latch DIR, MODE, COUNT. If COUNT=0, go to FIN with Q unchanged; else go to SHIFT with remaining=COUNT.
  - else Q holds.
- SHIFT:
  - Each edge performs exactly one 1-bit shift on Q using the latched DIR/MODE, then remaining decrements.
  - When remaining=1 at an edge, that shift is the last one and the next state is FIN.
  - BUSY=1 throughout SHIFT.
  - LD, START and changes on DIR/MODE/COUNT are ignored.
  - LeftIn/RightIn are sampled live each shift edge.
- FIN: DONE=1, BUSY=0 for exactly one cycle, then IDLE. LD/START are ignored in FIN.
- Latency: START sampled at edge 0. Shifts occur at edges 1..N. DONE is high in the cycle after edge N (after edge 0 if N=0). The next command can be accepted at edge N+2.
- Shift rules:
  - Logical left: Q<<1, LSB=0.
  - Logical right: Q>>1, MSB=0.
  - Arithmetic left: identical to logical left.
  - Arithmetic right: MSB replicated.
  - Rotate left: LSB<=old MSB.
  - Rotate right: MSB<=old LSB.
  - Serial left: LSB<=RightIn.
  - Serial right: MSB<=LeftIn.
- COUNT >= DATA_WIDTH is legal and is performed literally (rotate by DATA_WIDTH returns the original value; logical by DATA_WIDTH yields 0).
- BUSY and DONE are registered outputs decoded from state; they are never high together.

Optional Feature:
- Macro: SHREG_CARRY_EN.
- Defined: adds output port CARRY (1 bit), reset 0. Updated on each SHIFT edge with the bit shifted out (old MSB for left, old LSB for right, all modes including rotate). Held in IDLE/FIN. Cleared to 0 on LD.
- Undefined: no CARRY port, no associated logic.

Test Plan (DATA_WIDTH=8, CNT_W=4):
- Logical right: LD D=0xB4; START DIR=1 MODE=00 COUNT=3 -> BUSY high 3 cycles; Q=0x16; DONE pulses once in the cycle after the third shift.
- Arithmetic right: LD 0xB4; START DIR=1 MODE=01 COUNT=2 -> Q=0xED. Repeat with LD 0x34 -> Q=0x0D.
- Rotate left: LD 0x81; START DIR=0 MODE=10 COUNT=1 -> Q=0x03. Then START COUNT=8 -> Q=0x03 unchanged; DONE after 8 shifts.
- Serial left and zero count: LD 0x00; START DIR=0 MODE=11 COUNT=4 with RightIn=1,0,1,1 on successive shift edges -> Q=0x0B. START COUNT=0 -> DONE in the next cycle, BUSY never high, Q unchanged.
- Ignore and reset: during BUSY apply LD D=0xFF and START -> ignored, Q follows the shift sequence. Assert RST on the 2nd shift edge -> Q=0x00, BUSY=0, DONE=0 next cycle, and no DONE pulse afterwards.
- SHREG_CARRY_EN build: LD 0x80; START DIR=0 MODE=00 COUNT=1 -> Q=0x00, CARRY=1. Then LD 0x01 -> CARRY=0.
